// File: rtl/agc_mon_pkg.sv
// Shared definitions for the AGC monitor-port sequencer: op codes, FSM states, MT bit indices.
package agc_mon_pkg;

    localparam logic [2:0] MON_NOP   = 3'd0;
    localparam logic [2:0] MON_START = 3'd1;
    localparam logic [2:0] MON_STOP  = 3'd2;
    localparam logic [2:0] MON_LOAD  = 3'd3;
    localparam logic [2:0] MON_READ  = 3'd4;
    localparam logic [2:0] MON_LDCH  = 3'd5;
    localparam logic [2:0] MON_RDCH  = 3'd6;
    localparam logic [2:0] MON_RSVD  = 3'd7;

    localparam int unsigned MT01_IDX = 0;
    localparam int unsigned MT10_IDX = 9;
    localparam int unsigned MT12_IDX = 11;

    // StDecode gives the accepted command one cycle to route, which sets the 2-cycle latency.
    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StPulse,
        StAlign,
        StDrive,
        StResp
    } mon_state_e;

    function automatic logic op_is_load(input logic [2:0] op);
        return (op == MON_LOAD) || (op == MON_LDCH);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == MON_READ) || (op == MON_RDCH);
    endfunction

endpackage

// File: rtl/agc_mon_edge.sv
// Registered copy of the MT timing pulses with registered MT10/MT12 rise detects and an
// any-edge flag, all one cycle behind the input.
module agc_mon_edge
    import agc_mon_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] mt_i,
    output logic        mt10_rise_o,
    output logic        mt12_rise_o,
    output logic        mt_edge_o
);

    logic [11:0] mt_q;
    logic        mt10_rise_q;
    logic        mt12_rise_q;
    logic        mt_edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mt_q        <= '0;
            mt10_rise_q <= 1'b0;
            mt12_rise_q <= 1'b0;
            mt_edge_q   <= 1'b0;
        end else begin
            mt_q        <= mt_i;
            mt10_rise_q <= mt_i[MT10_IDX] & ~mt_q[MT10_IDX];
            mt12_rise_q <= mt_i[MT12_IDX] & ~mt_q[MT12_IDX];
            mt_edge_q   <= |(mt_i ^ mt_q);
        end
    end

    assign mt10_rise_o = mt10_rise_q;
    assign mt12_rise_o = mt12_rise_q;
    assign mt_edge_o   = mt_edge_q;

endmodule

// File: rtl/agc_monitor_seq.sv
// Sequences the AGC monitor port for one valid/ready requester. Define AGC_MON_TIMEOUT_EN to
// abort ALIGN/DRIVE waits after TIMEOUT cycles without an MT edge.
module agc_monitor_seq
    import agc_mon_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 256,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic [11:0] MT,
    input  logic        MGOJAM,
    input  logic [15:0] MWL,
    output logic [15:0] MDT,
    output logic        MSTRT,
    output logic        MSTP,
    output logic        MLOAD,
    output logic        MREAD,
    output logic        MLDCH,
    output logic        MRDCH
);

    mon_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        mstrt_q, mstrt_d;
    logic        mstp_q, mstp_d;
    logic        mload_q, mload_d;
    logic        mread_q, mread_d;
    logic        mldch_q, mldch_d;
    logic        mrdch_q, mrdch_d;
    logic [15:0] mdt_q, mdt_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic mt10_rise;
    logic mt12_rise;
    logic mt_edge;
    logic tmo_hit;
    logic abort;

    agc_mon_edge u_edge (
        .clk_i       (SIM_CLK),
        .rst_ni      (SIM_RST_n),
        .mt_i        (MT),
        .mt10_rise_o (mt10_rise),
        .mt12_rise_o (mt12_rise),
        .mt_edge_o   (mt_edge)
    );

`ifdef AGC_MON_TIMEOUT_EN
    assign tmo_hit = ((state_q == StAlign) || (state_q == StDrive)) && (cnt_q >= TIMEOUT);
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = mt_edge ^ (TIMEOUT == 0);
`endif

    // GOJAM and timeout share one abort path; it outranks a coincident mt12_rise.
    assign abort = MGOJAM | tmo_hit;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        mstrt_d    = mstrt_q;
        mstp_d     = mstp_q;
        mload_d    = mload_q;
        mread_d    = mread_q;
        mldch_d    = mldch_q;
        mrdch_d    = mrdch_q;
        mdt_d      = mdt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    op_d       = cmd_op;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                case (op_q)
                    MON_NOP: state_d = StResp;
                    MON_START: begin
                        mstrt_d = 1'b1;
                        cnt_d   = PULSE_LEN - 1;
                        state_d = StPulse;
                    end
                    MON_STOP: begin
                        mstp_d  = 1'b1;
                        state_d = StResp;
                    end
                    MON_LOAD, MON_READ, MON_LDCH, MON_RDCH: begin
                        cnt_d   = '0;
                        state_d = StAlign;
                    end
                    default: begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end
                endcase
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    mstrt_d = 1'b0;
                    mstp_d  = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StAlign, StDrive: begin
`ifdef AGC_MON_TIMEOUT_EN
                cnt_d = mt_edge ? '0 : cnt_q + 32'd1;
`endif
                if (abort) begin
                    {mload_d, mread_d, mldch_d, mrdch_d} = '0;
                    mdt_d      = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else if (state_q == StAlign) begin
                    if (mt12_rise) begin
                        mload_d = (op_q == MON_LOAD);
                        mread_d = (op_q == MON_READ);
                        mldch_d = (op_q == MON_LDCH);
                        mrdch_d = (op_q == MON_RDCH);
                        mdt_d   = op_is_load(op_q) ? data_q : '0;
                        cnt_d   = '0;
                        state_d = StDrive;
                    end
                end else begin
                    if (mt10_rise && op_is_read(op_q)) begin
                        rsp_data_d = MWL;
                    end
                    if (mt12_rise) begin
                        {mload_d, mread_d, mldch_d, mrdch_d} = '0;
                        mdt_d   = '0;
                        state_d = StResp;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Registered so cmd_ready stays low through reset and rises one cycle after release.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q    <= StIdle;
            op_q       <= MON_NOP;
            data_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            mstrt_q    <= 1'b0;
            mstp_q     <= 1'b0;
            mload_q    <= 1'b0;
            mread_q    <= 1'b0;
            mldch_q    <= 1'b0;
            mrdch_q    <= 1'b0;
            mdt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            mstrt_q    <= mstrt_d;
            mstp_q     <= mstp_d;
            mload_q    <= mload_d;
            mread_q    <= mread_d;
            mldch_q    <= mldch_d;
            mrdch_q    <= mrdch_d;
            mdt_q      <= mdt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_valid ? rsp_data_q : '0;
    assign rsp_err   = rsp_valid & rsp_err_q;
    assign MDT       = mdt_q;
    assign MSTRT     = mstrt_q;
    assign MSTP      = mstp_q;
    assign MLOAD     = mload_q;
    assign MREAD     = mread_q;
    assign MLDCH     = mldch_q;
    assign MRDCH     = mrdch_q;

endmodule

// File: tb/tb_agc_monitor_seq.sv
// Directed self-checking bench for agc_monitor_seq (PULSE_LEN=4, TIMEOUT=100); also builds
// with AGC_MON_TIMEOUT_EN defined.
module tb_agc_monitor_seq;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_STRT = 3'd1;
    localparam logic [2:0] OP_STOP = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_READ = 3'd4;
    localparam logic [2:0] OP_LDCH = 3'd5;
    localparam logic [2:0] OP_RDCH = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [11:0] MT;
    logic        MGOJAM;
    logic [15:0] MWL;
    logic [15:0] MDT;
    logic        MSTRT, MSTP, MLOAD, MREAD, MLDCH, MRDCH;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int phase = 0;
    int mt12_cyc = -1000;
    int acc = 0;
    bit mt_run = 1'b0;

    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic [15:0] rsp_d = '0;
    logic        rsp_e = 1'b0;
    int          st_rise_cyc = 0, st_fall_cyc = 0, st_rise_rel = 0, st_fall_rel = 0;
    int          mstrt_cnt = 0;
    logic [15:0] mdt_at_rise = '0;
    bit          mdt_bad = 1'b0;
    bit          multi = 1'b0;
    logic [4:0]  st, prev_st = '0;

    always #5 clk = ~clk;

    agc_monitor_seq #(
        .PULSE_LEN (4),
        .TIMEOUT   (100)
    ) dut (
        .SIM_CLK   (clk),
        .SIM_RST_n (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .MT        (MT),
        .MGOJAM    (MGOJAM),
        .MWL       (MWL),
        .MDT       (MDT),
        .MSTRT     (MSTRT),
        .MSTP      (MSTP),
        .MLOAD     (MLOAD),
        .MREAD     (MREAD),
        .MLDCH     (MLDCH),
        .MRDCH     (MRDCH)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, log strobe/response events, then advance MT/MWL.
    // MCT = 24 cycles, each MTnn high for 2 cycles; MWL carries A5A5 only while MT10 is high.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        st = {MSTRT, MLOAD, MREAD, MLDCH, MRDCH};
        if ((|st) && !(|prev_st)) begin
            st_rise_cyc = cyc;
            st_rise_rel = cyc - mt12_cyc;
            mdt_at_rise = MDT;
        end
        if (!(|st) && (|prev_st)) begin
            st_fall_cyc = cyc;
            st_fall_rel = cyc - mt12_cyc;
        end
        if ((|st) && MDT !== mdt_at_rise) mdt_bad = 1'b1;
        if (!(|st) && MDT !== 16'h0) mdt_bad = 1'b1;
        if ($countones(st) > 1) multi = 1'b1;
        if (MSTRT) mstrt_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_d   = rsp_data;
            rsp_e   = rsp_err;
        end
        prev_st = st;
        if (mt_run) begin
            phase = (phase + 1) % 24;
            MT = 12'h1 << (phase / 2);
            if (phase == 22) mt12_cyc = cyc;
        end else begin
            MT = '0;
        end
        MWL = MT[9] ? 16'hA5A5 : 16'h5A5A;
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] d);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        chk("ready_before_send", 32'(cmd_ready), 32'd1);
        rsp_cnt   = 0;
        mstrt_cnt = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        acc       = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        chk("ready_drop_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_rsp(input int max);
        int n = 0;
        while (rsp_cnt == 0 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        MT        = '0;
        MGOJAM    = 1'b0;
        MWL       = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", 32'({MSTRT, MSTP, MLOAD, MREAD, MLDCH, MRDCH, rsp_valid}), 32'd0);
        chk("rst_mdt", 32'(MDT), 32'd0);
        rst_n = 1'b1;
        chk("ready_at_release", 32'(cmd_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // NOP and reserved op: 2-cycle latency
        send(OP_NOP, 16'hFFFF);
        wait_rsp(10);
        chk("nop_latency", 32'(rsp_cyc - acc), 32'd2);
        chk("nop_err", 32'(rsp_e), 32'd0);
        send(OP_RSVD, 16'h0);
        wait_rsp(10);
        chk("rsvd_latency", 32'(rsp_cyc - acc), 32'd2);
        chk("rsvd_err", 32'(rsp_e), 32'd1);

        // STOP sets the level; START pulses MSTRT for PULSE_LEN and clears it
        send(OP_STOP, 16'h0);
        wait_rsp(10);
        chk("stop_latency", 32'(rsp_cyc - acc), 32'd2);
        chk("stop_mstp", 32'(MSTP), 32'd1);
        send(OP_STRT, 16'h0);
        wait_rsp(20);
        chk("start_latency", 32'(rsp_cyc - acc), 32'd6);
        chk("start_mstrt_len", 32'(mstrt_cnt), 32'd4);
        chk("start_err", 32'(rsp_e), 32'd0);
        chk("start_mstp_clr", 32'(MSTP), 32'd0);

        // LOAD aligned to MT12
        mt_run = 1'b1;
        repeat (3) tick();
        send(OP_LOAD, 16'h1234);
        wait_rsp(100);
        chk("load_rsp", 32'(rsp_cnt), 32'd1);
        chk("load_rise_rel", 32'(st_rise_rel), 32'd2);
        chk("load_fall_rel", 32'(st_fall_rel), 32'd2);
        chk("load_span", 32'(st_fall_cyc - st_rise_cyc), 32'd24);
        chk("load_mdt", 32'(mdt_at_rise), 32'h1234);
        chk("load_err", 32'(rsp_e), 32'd0);
        repeat (3) tick();
        chk("load_single_rsp", 32'(rsp_cnt), 32'd1);
        chk("load_mdt_after", 32'(MDT), 32'd0);

        // READ captures MWL at MT10
        send(OP_READ, 16'hFFFF);
        wait_rsp(100);
        chk("read_rsp", 32'(rsp_cnt), 32'd1);
        chk("read_data", 32'(rsp_d), 32'hA5A5);
        chk("read_err", 32'(rsp_e), 32'd0);
        chk("read_span", 32'(st_fall_cyc - st_rise_cyc), 32'd24);
        chk("read_mdt", 32'(mdt_at_rise), 32'd0);

        // LDCH aborted by GOJAM mid-DRIVE
        send(OP_LDCH, 16'hBEEF);
        n = 0;
        while (!MLDCH && n < 60) begin
            tick();
            n++;
        end
        chk("ldch_strobe", 32'(MLDCH), 32'd1);
        chk("ldch_mdt", 32'(MDT), 32'hBEEF);
        repeat (3) tick();
        MGOJAM = 1'b1;
        tick();
        MGOJAM = 1'b0;
        chk("ldch_abort_drop", 32'(MLDCH), 32'd0);
        chk("ldch_abort_mdt", 32'(MDT), 32'd0);
        chk("ldch_abort_rsp", 32'(rsp_valid), 32'd1);
        chk("ldch_abort_err", 32'(rsp_err), 32'd1);
        chk("ldch_abort_data", 32'(rsp_data), 32'd0);

        // RDCH: GOJAM coincides with the closing mt12_rise after MWL was captured
        send(OP_RDCH, 16'h0);
        n = 0;
        while (!MRDCH && n < 60) begin
            tick();
            n++;
        end
        chk("rdch_strobe", 32'(MRDCH), 32'd1);
        n = 0;
        while (mt12_cyc != cyc && n < 40) begin
            tick();
            n++;
        end
        tick();
        MGOJAM = 1'b1;
        tick();
        MGOJAM = 1'b0;
        chk("rdch_same_cycle_rsp", 32'(rsp_cnt), 32'd1);
        chk("rdch_same_cycle_err", 32'(rsp_e), 32'd1);
        chk("rdch_same_cycle_data", 32'(rsp_d), 32'd0);
        chk("rdch_same_cycle_drop", 32'(MRDCH), 32'd0);

        // MT held low during RDCH
        mt_run = 1'b0;
        repeat (5) tick();
        send(OP_RDCH, 16'h0);
`ifdef AGC_MON_TIMEOUT_EN
        wait_rsp(300);
        chk("tmo_rsp", 32'(rsp_cnt), 32'd1);
        chk("tmo_err", 32'(rsp_e), 32'd1);
        chk("tmo_latency", 32'(rsp_cyc - acc), 32'd103);
`else
        repeat (10000) tick();
        chk("notmo_no_rsp", 32'(rsp_cnt), 32'd0);
        mt_run = 1'b1;
        wait_rsp(100);
        chk("notmo_resume_rsp", 32'(rsp_cnt), 32'd1);
        chk("notmo_resume_err", 32'(rsp_e), 32'd0);
        chk("notmo_resume_data", 32'(rsp_d), 32'hA5A5);
`endif

        // Async reset mid-DRIVE
        mt_run = 1'b1;
        send(OP_LOAD, 16'h00FF);
        n = 0;
        while (!MLOAD && n < 60) begin
            tick();
            n++;
        end
        chk("rstmid_mload_before", 32'(MLOAD), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_mload", 32'(MLOAD), 32'd0);
        chk("rstmid_mdt", 32'(MDT), 32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rstmid_ready_release", 32'(cmd_ready), 32'd0);
        tick();
        chk("rstmid_ready_after", 32'(cmd_ready), 32'd1);

        chk("one_hot_strobes", 32'(multi), 32'd0);
        chk("mdt_only_on_strobe_edges", 32'(mdt_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
